mu0_run_ctrl: RTL
=================

Name: mu0_run_ctrl

Overview:
- Run-control sequencer between the host debug interface and the MU0 core.
- Gates the core's clock enable to provide RUN, STEP-N, STOP and DUT-reset commands.
- Halts at an instruction boundary on step completion, breakpoint match or core STP.
- Keeps cycle and instruction counters readable by the debugger.

Parameters:
- RESET_CYCLES, 2, number of cycles dut_reset is held high, with dut_clk_en=1, per reset sequence (min 1).
- CYC_W, 32, width of cycle_count.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- cmd_valid  in  1  host command strobe.
- cmd_op  in  2  00 STOP, 01 RUN, 10 STEP, 11 RESET_DUT.
- cmd_arg  in  16  STEP instruction count N.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- dut_fetch  in  1  core is in a fetch cycle.
- dut_pc  in  12  core program counter.
- dut_stop  in  1  core has executed STP.
- bp_addr  in  12  breakpoint address.
- bp_enable  in  1  breakpoint armed.
- dut_clk_en  out  1  core advances this cycle.
- dut_reset  out  1  active-high reset to core.
- state  out  2  00 IDLE, 01 RUN, 10 STEP, 11 RESETTING.
- halt_reason  out  2  00 HOST, 01 STEP_DONE, 10 BREAKPOINT, 11 DUT_STOP.
- instr_count  out  16  executed fetches.
- cycle_count  out  CYC_W  enabled cycles.

Behaviour:
- rst low: state enters RESETTING with the reset counter loaded to RESET_CYCLES.
  - Counters are cleared, halt_reason=00, remaining=0.
  - Outputs while rst is low: dut_reset=1, dut_clk_en=0, cmd_ready=0.
- RESETTING: dut_reset=1, dut_clk_en=1 and cmd_ready=0 for exactly RESET_CYCLES cycles, then IDLE.
- Commands are accepted only while state!=RESETTING.
- cmd_ready is a registered function of state; it is 1 in IDLE, RUN and STEP.
- Transitions on an accepted command:
  - STOP: any state goes to IDLE, halt_reason=HOST.
  - RUN: goes to RUN. Ignored if already in RUN.
  - STEP: goes to STEP with remaining=cmd_arg. Reloads remaining if already in STEP.
  - RESET_DUT: goes to RESETTING and clears both counters.
- IDLE: dut_clk_en=0.
- RUN/STEP: dut_clk_en=1 unless a halt condition is true this cycle. Halt conditions are combinational on the current inputs:
  - dut_stop=1: halt_reason=DUT_STOP.
  - STEP with dut_fetch=1 and remaining==0: halt_reason=STEP_DONE.
  - Breakpoint: dut_fetch=1, bp_enable=1, dut_pc==bp_addr and skip_bp=0. halt_reason=BREAKPOINT.
  - Priority: DUT_STOP > STEP_DONE > BREAKPOINT.
  - On a halt: dut_clk_en=0 in that same cycle, and state is IDLE from the next cycle.
- skip_bp is set on any entry to RUN/STEP. It is cleared after the first enabled fetch, so resuming from a breakpoint executes the breakpointed instruction.
- STEP accounting: each enabled fetch (dut_fetch && dut_clk_en) decrements remaining.
  - STEP N executes exactly N instructions.
  - N=0 halts at the first fetch with STEP_DONE and zero instructions executed.
- Counters:
  - cycle_count increments on every cycle with dut_clk_en=1, including RESETTING.
  - instr_count increments on every enabled fetch.
  - Both wrap modulo 2^width.
- Simultaneous events:
  - An accepted command in the same cycle as a halt condition: the command wins the next state.
  - In that case dut_clk_en stays 0 for that cycle, and halt_reason updates only if the next state is IDLE.
- rst asserted mid-operation aborts immediately to the reset values.

Optional Feature:
- MU0_RUNCTRL_BREAKPOINT_EN
  - Defined: breakpoint comparison and skip_bp are implemented as above.
  - Undefined: bp_addr and bp_enable remain as ports but are ignored, skip_bp logic is removed, and halt_reason never equals 10.

Decomposition:
- Package mu0_runctrl_pkg holds:
  - cmd_op codes.
  - state encoding.
  - halt_reason encoding.
  - the 12-bit address width constant.
- Sub-module mu0_event_counter: parameterised width, with synchronous clear and increment enable. Instantiated twice, for cycles and instructions.

Test Plan:
- Release rst with RESET_CYCLES=2 -> dut_reset=1 for 2 cycles, then state=IDLE, cmd_ready=1, cycle_count=2.
- STEP N=3 with a fetch every 3rd cycle -> 3 fetches enabled, dut_clk_en=0 on the 4th fetch, instr_count=3, halt_reason=01.
- bp_addr=0x005, RUN with pc sequencing 0..5 -> halt with dut_clk_en=0 at pc 0x005 fetch, reason=10. A second RUN executes the 0x005 fetch, and instr_count advances.
- RUN, then dut_stop=1 -> same-cycle dut_clk_en=0, IDLE, reason=11. STEP N=0 from IDLE at a fetch -> immediate halt with reason=01 and instr_count unchanged.
- RUN, then STOP issued in the same cycle as a breakpoint hit -> IDLE, reason=00. RESET_DUT then clears both counters and cmd_ready=0 for 2 cycles.
- Build without MU0_RUNCTRL_BREAKPOINT_EN, bp_enable=1, pc=bp_addr -> no halt.

Source files
------------

// File: rtl/mu0_runctrl_pkg.sv
// Shared encodings for the MU0 run-control sequencer: host command codes,
// sequencer states, halt reasons and the core address width.
package mu0_runctrl_pkg;

    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        OP_STOP      = 2'b00,
        OP_RUN       = 2'b01,
        OP_STEP      = 2'b10,
        OP_RESET_DUT = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP      = 2'b10,
        ST_RESETTING = 2'b11
    } run_state_e;

    typedef enum logic [1:0] {
        HR_HOST       = 2'b00,
        HR_STEP_DONE  = 2'b01,
        HR_BREAKPOINT = 2'b10,
        HR_DUT_STOP   = 2'b11
    } halt_reason_e;

    function automatic logic is_active(input run_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/mu0_event_counter.sv
// Free-running wrap-around event counter with synchronous clear and increment
// enable; clear takes priority over increment.
module mu0_event_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // count register: reset/clear, else increment when enabled
    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mu0_run_ctrl.sv
// MU0 run-control sequencer: gates the core clock enable for RUN/STEP/STOP/RESET_DUT.
// Breakpoint support is compiled in only when MU0_RUNCTRL_BREAKPOINT_EN is defined.
module mu0_run_ctrl
    import mu0_runctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int CYC_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_arg,
    output logic              cmd_ready,
    input  logic              dut_fetch,
    input  logic [ADDR_W-1:0] dut_pc,
    input  logic              dut_stop,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_enable,
    output logic              dut_clk_en,
    output logic              dut_reset,
    output logic [1:0]        state,
    output logic [1:0]        halt_reason,
    output logic [15:0]       instr_count,
    output logic [CYC_W-1:0]  cycle_count
);

    localparam int RCW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);
    localparam logic [RCW-1:0] RC_LOAD = RCW'(RESET_CYCLES);

    run_state_e   r_state;
    halt_reason_e r_halt_reason;
    logic         r_cmd_ready;
    logic [15:0]  r_remaining;
    logic [RCW-1:0] r_rst_cnt;

    cmd_op_e      w_op;
    halt_reason_e w_halt_code;
    logic w_active, w_resetting, w_accept, w_cmd_eff;
    logic w_stop_hit, w_step_hit, w_bp_hit, w_halt;
    logic w_clk_en, w_fetch_en, w_cnt_clr;

    assign w_op        = cmd_op_e'(cmd_op);
    assign w_active    = is_active(r_state);
    assign w_resetting = (r_state == ST_RESETTING);
    assign w_accept    = cmd_valid && cmd_ready;
    // RUN while already running is a no-op and must not disturb a pending halt
    assign w_cmd_eff   = w_accept && !((w_op == OP_RUN) && (r_state == ST_RUN));

    assign w_stop_hit = w_active && dut_stop;
    assign w_step_hit = (r_state == ST_STEP) && dut_fetch && (r_remaining == 16'd0);

`ifdef MU0_RUNCTRL_BREAKPOINT_EN
    logic r_skip_bp;

    assign w_bp_hit = w_active && dut_fetch && bp_enable && (dut_pc == bp_addr) && !r_skip_bp;

    // skip flag lets a resume execute the instruction it halted on
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_skip_bp <= 1'b0;
        end else if (w_cmd_eff && ((w_op == OP_RUN) || (w_op == OP_STEP))) begin
            r_skip_bp <= 1'b1;
        end else if (w_active && w_fetch_en) begin
            r_skip_bp <= 1'b0;
        end else begin
            r_skip_bp <= r_skip_bp;
        end
    end
`else
    logic w_unused_bp;
    assign w_unused_bp = ^{bp_addr, bp_enable, dut_pc};
    assign w_bp_hit    = 1'b0;
`endif

    assign w_halt = w_stop_hit || w_step_hit || w_bp_hit;

    // halt reason priority: DUT_STOP > STEP_DONE > BREAKPOINT
    always_comb begin
        w_halt_code = HR_HOST;
        if (w_stop_hit) begin
            w_halt_code = HR_DUT_STOP;
        end else if (w_step_hit) begin
            w_halt_code = HR_STEP_DONE;
        end else if (w_bp_hit) begin
            w_halt_code = HR_BREAKPOINT;
        end else begin
            w_halt_code = HR_HOST;
        end
    end

    assign w_clk_en   = rst && (w_resetting || (w_active && !w_halt));
    assign w_fetch_en = w_clk_en && dut_fetch;
    assign w_cnt_clr  = w_cmd_eff && (w_op == OP_RESET_DUT);

    // sequencer: accepted command beats a same-cycle halt
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_RESETTING;
            r_rst_cnt     <= RC_LOAD;
            r_halt_reason <= HR_HOST;
            r_remaining   <= 16'd0;
            r_cmd_ready   <= 1'b0;
        end else if (w_cmd_eff) begin
            case (w_op)
                OP_STOP: begin
                    r_state       <= ST_IDLE;
                    r_halt_reason <= HR_HOST;
                    r_cmd_ready   <= 1'b1;
                end
                OP_RUN: begin
                    r_state     <= ST_RUN;
                    r_cmd_ready <= 1'b1;
                end
                OP_STEP: begin
                    r_state     <= ST_STEP;
                    r_remaining <= cmd_arg;
                    r_cmd_ready <= 1'b1;
                end
                OP_RESET_DUT: begin
                    r_state     <= ST_RESETTING;
                    r_rst_cnt   <= RC_LOAD;
                    r_cmd_ready <= 1'b0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end else if (w_halt) begin
            r_state       <= ST_IDLE;
            r_halt_reason <= w_halt_code;
            r_cmd_ready   <= 1'b1;
        end else begin
            case (r_state)
                ST_RESETTING: begin
                    if (r_rst_cnt <= RCW'(1)) begin
                        r_state     <= ST_IDLE;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_rst_cnt   <= r_rst_cnt - RCW'(1);
                        r_cmd_ready <= 1'b0;
                    end
                end
                ST_STEP: begin
                    r_cmd_ready <= 1'b1;
                    if (w_fetch_en) begin
                        r_remaining <= r_remaining - 16'd1;
                    end else begin
                        r_remaining <= r_remaining;
                    end
                end
                default: begin
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    mu0_event_counter #(.WIDTH(CYC_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_clk_en),
        .o_count (cycle_count)
    );

    mu0_event_counter #(.WIDTH(16)) u_instr_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_fetch_en),
        .o_count (instr_count)
    );

    assign dut_clk_en  = w_clk_en;
    assign dut_reset   = !rst || w_resetting;
    assign cmd_ready   = r_cmd_ready && rst;
    assign state       = r_state;
    assign halt_reason = r_halt_reason;

endmodule
